// File: rtl/platypus_pkg.sv
// Shared constants and elaboration-time helpers for the DAQ gearbox FIFO.
// Holds the width/depth defaults, clog2 and the parameter legality checks.
package platypus_pkg;

  localparam int unsigned DEF_DIN_W = 16;
  localparam int unsigned DEF_DEPTH = 1024;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // The gearbox only splits words into 1, 2 or 4 equal slices.
  function automatic bit ratio_ok(input int unsigned ratio, input int unsigned din_w);
    return ((ratio == 1) || (ratio == 2) || (ratio == 4)) && ((din_w % ratio) == 0);
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/platypus_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module platypus_sdp_ram
  import platypus_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DIN_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/daq_gearbox_fifo.sv
// Word-wide write, slice-wide read FIFO: each stored word is returned as RATIO
// narrower slices, and the word is freed only after its last slice is read.
module daq_gearbox_fifo
  import platypus_pkg::*;
#(
  parameter int unsigned DIN_W     = DEF_DIN_W,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned AFULL_LVL = DEPTH - 4,
  localparam int unsigned DOUT_W   = DIN_W / RATIO,
  localparam int unsigned LVL_W    = clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DIN_W-1:0]  wr_data_i,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  input  logic              rd_en_i,
  output logic [DOUT_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              empty_o,
  output logic              underflow_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              err_o
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned SW = (RATIO > 1) ? clog2(RATIO) : 1;

  if (!ratio_ok(RATIO, DIN_W)) begin : g_bad_ratio
    $error("daq_gearbox_fifo: RATIO must be 1, 2 or 4 and divide DIN_W");
  end
  if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_bad_depth
    $error("daq_gearbox_fifo: DEPTH must be a power of two, at least 4");
  end

  // Reset asserts at once and releases two clock edges after reset_i falls.
  logic [1:0] rst_sync;
  logic       rst;

  // NOTE: every clocked register in this design is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rst_sync <= 2'b11;
    else         rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  logic [AW:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [SW-1:0]      slice_cnt;
  logic               full_q, empty_q, full_nxt, empty_nxt;
  logic               wr_acc, rd_acc, last_slice, word_done;
  logic               ovf_now, udf_now;
  logic               byp_q;
  logic [DIN_W-1:0]   byp_data, ram_q, head_word;
  logic [DOUT_W-1:0]  rd_slice;
  int unsigned        slice_idx;

  assign wr_acc     = wr_en_i & ~full_q  & ~flush_i & ~rst;
  assign rd_acc     = rd_en_i & ~empty_q & ~flush_i & ~rst;
  assign ovf_now    = wr_en_i &  full_q  & ~flush_i;
  assign udf_now    = rd_en_i &  empty_q & ~flush_i;
  assign last_slice = (slice_cnt == SW'(RATIO - 1));
  assign word_done  = rd_acc & last_slice;

  // NOTE: next-state signals get a default before any condition so no latch is inferred.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (wr_acc)    wr_ptr_nxt = wr_ptr + (AW + 1)'(1);
      if (word_done) rd_ptr_nxt = rd_ptr + (AW + 1)'(1);
    end
  end

  // The extra pointer MSB separates a full ring from an empty one.
  assign full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      slice_cnt <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      byp_q     <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
      byp_q   <= wr_acc && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      if (flush_i)     slice_cnt <= '0;
      else if (rd_acc) slice_cnt <= last_slice ? '0 : slice_cnt + SW'(1);
    end
  end

  // Copy of a word written into the slot the RAM is reading this same cycle.
  always_ff @(posedge clk_i) begin
    if (wr_acc) byp_data <= wr_data_i;
  end

  platypus_sdp_ram #(
    .WIDTH (DIN_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data_i),
    .rd_addr (rd_ptr_nxt[AW-1:0]),
    .rd_data (ram_q)
  );

  assign head_word = byp_q ? byp_data : ram_q;

  always_comb begin
    slice_idx = 32'(slice_cnt);
    if (MSB_FIRST) slice_idx = RATIO - 1 - slice_idx;
    rd_slice = DOUT_W'(head_word >> (slice_idx * DOUT_W));
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      rd_valid_o  <= rd_acc;
      overflow_o  <= ovf_now;
      underflow_o <= udf_now;
      if (rd_acc) rd_data_o <= rd_slice;
      if (flush_i) err_o <= 1'b0;
      else         err_o <= err_o | ovf_now | udf_now;
    end
  end

  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign level_o       = wr_ptr - rd_ptr;
  assign almost_full_o = ~rst & (32'(level_o) >= AFULL_LVL);

endmodule

// File: tb/tb_daq_gearbox_fifo.sv
// Directed bench for daq_gearbox_fifo: default 16->8 instance plus a 32->8 LSB-first
// instance, ending with a random stream checked against a queue model.
module tb_daq_gearbox_fifo;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, afull, ovf, rd_valid, empty, udf, err;
  logic [7:0]  rd_data;
  logic [10:0] level;

  logic        flush2 = 1'b0, wr_en2 = 1'b0, rd_en2 = 1'b0;
  logic [31:0] wr_data2 = '0;
  logic        full2, afull2, ovf2, rd_valid2, empty2, udf2, err2;
  logic [7:0]  rd_data2;
  logic [3:0]  level2;

  daq_gearbox_fifo dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full), .almost_full_o(afull), .overflow_o(ovf),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .empty_o(empty), .underflow_o(udf), .level_o(level), .err_o(err)
  );

  daq_gearbox_fifo #(.DIN_W(32), .RATIO(4), .DEPTH(8), .MSB_FIRST(1'b0)) dut2 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush2),
    .wr_en_i(wr_en2), .wr_data_i(wr_data2),
    .full_o(full2), .almost_full_o(afull2), .overflow_o(ovf2),
    .rd_en_i(rd_en2), .rd_data_o(rd_data2), .rd_valid_o(rd_valid2),
    .empty_o(empty2), .underflow_o(udf2), .level_o(level2), .err_o(err2)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] slc(input logic [15:0] w, input int k);
    logic [15:0] t;
    t = w >> (8 * (1 - k));
    return t[7:0];
  endfunction

  // Reference model for the streaming phase.
  logic [15:0] mq[$];
  int          mcnt = 0;
  logic        m_err = 1'b0;
  logic [7:0]  m_rd_data = '0;
  int          bad = 0;
  int          words_written = 0;

  task automatic model_step(input logic we, input logic re, input logic [15:0] wd);
    logic m_full, m_empty, e_ovf, e_udf, e_valid;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    e_ovf   = we && m_full;
    e_udf   = re && m_empty;
    e_valid = re && !m_empty;
    if (e_valid) begin
      m_rd_data = slc(mq[0], mcnt);
      mcnt++;
      if (mcnt == 2) begin
        void'(mq.pop_front());
        mcnt = 0;
      end
    end
    if (we && !m_full) begin
      mq.push_back(wd);
      words_written++;
    end
    m_err = m_err | e_ovf | e_udf;
    wr_en = we; rd_en = re; wr_data = wd;
    tick();
    if (rd_valid !== e_valid || (e_valid && rd_data !== m_rd_data) || rd_data !== m_rd_data ||
        ovf !== e_ovf || udf !== e_udf || err !== m_err ||
        32'(level) !== mq.size() || empty !== (mq.size() == 0) ||
        full !== (mq.size() == DEPTH) || afull !== (mq.size() >= DEPTH - 4))
      bad++;
  endtask

  initial begin
    // ---- reset state ----
    #1 reset = 1'b1;
    #1;
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_full_afull_err", {full, afull, err, ovf, udf}, 0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("post_rst_empty", empty, 1);

    // ---- basic two-word gearbox ----
    wr_en = 1; wr_data = 16'hA1B2; tick();
    check("w1_level", level, 1);
    check("w1_empty", empty, 0);
    wr_data = 16'hC3D4; tick();
    check("w2_level", level, 2);
    wr_en = 0; rd_en = 1; tick();
    check("r1_data", rd_data, 8'hA1); check("r1_valid", rd_valid, 1); check("r1_level", level, 2);
    tick();
    check("r2_data", rd_data, 8'hB2); check("r2_level", level, 1);
    tick();
    check("r3_data", rd_data, 8'hC3); check("r3_level", level, 1);
    tick();
    check("r4_data", rd_data, 8'hD4); check("r4_level", level, 0); check("r4_empty", empty, 1);
    rd_en = 0; tick();
    check("idle_valid", rd_valid, 0);
    check("idle_hold", rd_data, 8'hD4);

    // ---- LSB-first 32->8 instance ----
    wr_en2 = 1; wr_data2 = 32'h11223344; tick();
    wr_en2 = 0; rd_en2 = 1; tick();
    check("lsb_s0", rd_data2, 8'h44); check("lsb_lvl0", level2, 1);
    tick(); check("lsb_s1", rd_data2, 8'h33);
    tick(); check("lsb_s2", rd_data2, 8'h22);
    tick(); check("lsb_s3", rd_data2, 8'h11);
    check("lsb_empty", empty2, 1); check("lsb_level", level2, 0);
    rd_en2 = 0;

    // ---- fill to full, overflow ----
    wr_en = 1;
    for (int i = 0; i < 1019; i++) begin
      wr_data = 16'h8000 | 16'(i);
      tick();
    end
    check("fill_1019_level", level, 1019);
    check("fill_1019_afull", afull, 0);
    wr_data = 16'h8000 | 16'(1019); tick();
    check("fill_1020_afull", afull, 1);
    check("fill_1020_full", full, 0);
    for (int i = 1020; i < 1024; i++) begin
      wr_data = 16'h8000 | 16'(i);
      tick();
    end
    check("fill_full", full, 1);
    check("fill_level", level, 1024);
    wr_data = 16'hFFFF; tick();
    check("ovf_pulse", ovf, 1);
    check("ovf_err", err, 1);
    check("ovf_level", level, 1024);
    wr_en = 0; tick();
    check("ovf_once", ovf, 0);
    wr_en = 1; rd_en = 1; tick();
    check("ovf_rd_pulse", ovf, 1);
    check("ovf_rd_data", rd_data, 8'h80);
    check("ovf_rd_level", level, 1024);
    wr_en = 0;
    bad = 0;
    for (int k = 1; k < 2048; k++) begin
      tick();
      if (rd_valid !== 1'b1 || rd_data !== slc(16'h8000 | 16'(k / 2), k % 2)) bad++;
    end
    check("drain_data", bad, 0);
    check("drain_empty", empty, 1);
    check("drain_level", level, 0);

    // ---- read-when-empty with same-cycle write ----
    wr_en = 1; wr_data = 16'hBEEF; rd_en = 1; tick();
    check("udf_pulse", udf, 1);
    check("udf_valid", rd_valid, 0);
    check("udf_hold", rd_data, 8'hFF);
    check("udf_level", level, 1);
    wr_en = 0; tick();
    check("udf_next_data", rd_data, 8'hBE);
    check("udf_next_valid", rd_valid, 1);
    check("udf_clear", udf, 0);
    tick();
    check("udf_lo", rd_data, 8'hEF);
    check("udf_empty", empty, 1);
    rd_en = 0;
    check("err_sticky", err, 1);

    // ---- flush mid-word ----
    wr_en = 1;
    wr_data = 16'h1111; tick();
    wr_data = 16'h2222; tick();
    wr_data = 16'h3333; tick();
    wr_en = 0; rd_en = 1; tick();
    check("pre_flush_data", rd_data, 8'h11);
    check("pre_flush_level", level, 3);
    rd_en = 0; wr_en = 1; wr_data = 16'h9999; flush = 1; tick();
    flush = 0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_err", err, 0);
    check("flush_valid", rd_valid, 0);
    check("flush_hold", rd_data, 8'h11);
    wr_data = 16'h4455; tick();
    wr_en = 0; rd_en = 1; tick();
    check("post_flush_msb", rd_data, 8'h44);
    tick();
    check("post_flush_lsb", rd_data, 8'h55);
    check("post_flush_empty", empty, 1);
    rd_en = 0;

    // ---- asynchronous reset mid-stream ----
    wr_en = 1; wr_data = 16'hA5A5; tick();
    wr_data = 16'h5A5A; tick();
    wr_en = 0; rd_en = 1; tick();
    check("mid_data", rd_data, 8'hA5);
    check("mid_level", level, 2);
    wr_en = 1; wr_data = 16'h7777;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_level", level, 0);
    check("async_empty", empty, 1);
    check("async_rd_data", rd_data, 0);
    check("async_rd_valid", rd_valid, 0);
    wr_en = 0; rd_en = 0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("rel_empty", empty, 1);
    check("rel_level", level, 0);

    // ---- random stream across pointer wrap ----
    bad = 0;
    for (int cyc = 0; cyc < 30000 && words_written < 4000; cyc++) begin
      int wt, rt;
      if (((cyc / 2000) % 2) == 0) begin wt = 80; rt = 30; end
      else                         begin wt = 20; rt = 95; end
      model_step($urandom_range(0, 99) < wt, $urandom_range(0, 99) < rt, 16'($urandom));
    end
    check("stream_words", words_written >= 4000, 1);
    check("stream_match", bad, 0);
    for (int i = 0; i < 2 * DEPTH + 4; i++) model_step(1'b0, 1'b1, 16'h0);
    check("stream_drain_match", bad, 0);
    check("stream_drain_empty", empty, 1);
    rd_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/daq_gearbox_fifo.md
DAQ_GEARBOX_FIFO -- requirements
Module: daq_gearbox_fifo

Interface
REQ-001 The block SHALL have parameter DIN_W, default 16: write word width in bits.
REQ-002 The block SHALL have parameter RATIO, default 2: narrow slices per write word; legal values 1, 2, 4; DIN_W divisible by RATIO.
REQ-003 The block SHALL have parameter DEPTH, default 1024: storage in write words; power of two, at least 4.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1: 1 = slice [DIN_W-1 -: DOUT_W] read first; 0 = LSB slice first.
REQ-005 The block SHALL have parameter AFULL_LVL, default DEPTH-4: word level at or above which almost_full_o asserts.
REQ-006 The block SHALL have derived constants DOUT_W = DIN_W/RATIO and LVL_W = clog2(DEPTH)+1.
REQ-007 The block SHALL have port clk_i, input, 1 bit: single clock for both sides.
REQ-008 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port flush_i, input, 1 bit: synchronous clear of contents and sticky flags.
REQ-010 The block SHALL have port wr_en_i, input, 1 bit: write request.
REQ-011 The block SHALL have port wr_data_i, input, DIN_W bits: write word.
REQ-012 The block SHALL have port full_o, output, 1 bit: DEPTH words occupied.
REQ-013 The block SHALL have port almost_full_o, output, 1 bit: level_o >= AFULL_LVL.
REQ-014 The block SHALL have port overflow_o, output, 1 bit: one-cycle pulse on a rejected write.
REQ-015 The block SHALL have port rd_en_i, input, 1 bit: slice read request.
REQ-016 The block SHALL have port rd_data_o, output, DOUT_W bits: read slice, registered.
REQ-017 The block SHALL have port rd_valid_o, output, 1 bit: rd_data_o valid this cycle.
REQ-018 The block SHALL have port empty_o, output, 1 bit: no unread slices remain.
REQ-019 The block SHALL have port underflow_o, output, 1 bit: one-cycle pulse on a rejected read.
REQ-020 The block SHALL have port level_o, output, LVL_W bits: words occupied, a partially read word included.
REQ-021 The block SHALL have port err_o, output, 1 bit: sticky flag, set by any overflow or underflow.

Function
REQ-022 A write SHALL be accepted when wr_en_i=1 and full_o=0; the word is stored and the write pointer advances modulo DEPTH.
REQ-023 A write with full_o=1 SHALL be dropped, pulse overflow_o the next cycle, and leave pointers and level_o unchanged, even if a read occurs that cycle.
REQ-024 A read SHALL be accepted when rd_en_i=1 and empty_o=0; rd_data_o SHALL present the selected slice one cycle later with rd_valid_o=1 (latency 1).
REQ-025 A read with empty_o=1 SHALL pulse underflow_o the next cycle, keep rd_valid_o=0, and hold rd_data_o; a same-cycle write SHALL NOT satisfy that read.
REQ-026 A slice counter 0..RATIO-1 SHALL advance on each accepted read; the word SHALL be released (read pointer +1, level -1) only when its last slice is read.
REQ-027 Slice order SHALL follow MSB_FIRST; RATIO=1 SHALL behave as a plain synchronous FIFO.
REQ-028 On a simultaneous accepted write and word-releasing read, level_o SHALL be unchanged.
REQ-029 empty_o and full_o SHALL be registered and correct on the cycle after the causing access; back-to-back reads and writes SHALL sustain one access per cycle each.
REQ-030 Pointer wrap SHALL use an extra MSB so that full and empty stay distinct at DEPTH.
REQ-031 flush_i SHALL have priority over wr_en_i and rd_en_i; the next cycle SHALL show level_o=0, empty_o=1, slice counter 0, err_o=0, and rd_data_o held.

Reset
REQ-032 While reset_i=1, all outputs SHALL be 0 except empty_o=1; this includes rd_data_o, level_o, err_o, and all pulses.
REQ-033 Reset SHALL take effect immediately, abandoning any in-progress partial word; release SHALL be synchronous to clk_i through a 2-flop deassert synchroniser; RAM contents need not be cleared.

Structure
REQ-034 The package platypus_pkg SHALL hold clog2, the legal-RATIO check, and the default DIN_W and DEPTH constants.
REQ-035 Storage SHALL be one sub-module, platypus_sdp_ram: simple dual-port, DIN_W x DEPTH, one write port and one registered read port, inferable as block RAM.
REQ-036 Slice selection and the output register SHALL live in daq_gearbox_fifo.

Verification
REQ-037 With defaults, write 0xA1B2 then 0xC3D4, then read 4 slices: SHALL return 0xA1, 0xB2, 0xC3, 0xD4 with level_o going 2→2→1→1→0 and empty_o=1 after the last read.
REQ-038 With MSB_FIRST=0 and RATIO=4, DIN_W=32, write 0x11223344: reads SHALL return 0x44, 0x33, 0x22, 0x11.
REQ-039 Write 1024 words (full_o=1, almost_full_o from level 1020), then one more write: overflow_o SHALL pulse once, err_o=1, and the stored data SHALL be unchanged.
REQ-040 Read when empty while writing in the same cycle: underflow_o SHALL pulse, and the word SHALL be readable the following cycle.
REQ-041 Fill 3 words, read 1 slice, assert flush_i: level_o=0 and empty_o=1 the next cycle; the next write/read SHALL return the new word's MSB slice.
REQ-042 Assert reset_i asynchronously mid-stream between clock edges: outputs SHALL go to reset values before the next edge; after release, streaming 4000 random words with random enables SHALL match the reference model across pointer wrap.
